regfile_issue_scoreboard: RTL
=============================

Name: regfile_issue_scoreboard

Overview:
- Issue-stage controller between IDU and EXU that sequences access to the 16-entry integer register file (RV32E indexing, low 4 bits of each register field).
- Holds one decoded instruction in a skid buffer.
- Tracks outstanding register writes with per-register pending counters.
- Issues to EXU only when no RAW or counter-overflow hazard exists. Counters are released by WBU commit pulses and by kill notifications.

Parameters:
NREG, 16, number of architectural registers tracked (index width is log2(NREG) = 4)
CNT_WIDTH, 2, pending-write counter width per register (max 3 outstanding writes per register)
NUM_WIDTH, 64, width of the instruction sequence number carried alongside each instruction

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
id_valid  in  1  IDU offers an instruction
id_ready  out  1  scoreboard accepts the instruction this cycle
id_inst  in  32  instruction word from IDU
id_num  in  NUM_WIDTH  sequence number from IDU
ex_valid  out  1  buffered instruction is issued to EXU
ex_ready  in  1  EXU accepts the instruction
ex_inst  out  32  issued instruction word
ex_num  out  NUM_WIDTH  issued sequence number
wb_valid  in  1  single-cycle pulse: WBU committed an instruction (register file written this edge)
wb_inst  in  32  instruction word committed by WBU
kill_valid  in  1  single-cycle pulse: an already-issued instruction was squashed before writeback
kill_inst  in  32  instruction word of the squashed instruction
flush  in  1  drop the buffered (not yet issued) instruction
busy_mask  out  NREG  bit i set when pending counter i is non-zero
hazard_stall_cycles  out  32  count of cycles with a valid buffer entry blocked by a hazard

Behaviour:
- Clock and reset: one clock `clock`. Reset `reset` is synchronous and active-high.
- Reset values:
  - buffer empty; ex_valid=0; ex_inst=0; ex_num=0
  - all counters 0; busy_mask=0; hazard_stall_cycles=0
  - id_ready=1 in the first cycle after reset
- Decode (combinational, on any instruction word):
  - opcode=[6:0]; rd=[10:7]; rs1=[18:15]; rs2=[23:20]
  - wen when opcode is one of 0010011, 0110111, 0010111, 1110011, 1101111, 1100111, 0110011, 0000011, and rd!=0
  - uses_rs1 for all opcodes except 0110111, 0010111, 1101111
  - uses_rs2 for opcodes 0110011, 0100011, 1100011
  - register 0 never causes a hazard
- Hazard: buffer valid AND any of:
  - uses_rs1 with cnt[rs1]!=0
  - uses_rs2 with cnt[rs2]!=0
  - wen with cnt[rd]==2^CNT_WIDTH-1
- Hazard timing: evaluated on current-cycle counter values. There is no same-cycle writeback bypass: a wb_valid clearing a hazard lets the instruction issue in the following cycle, never in the same cycle.
- Issue:
  - ex_valid = buffer valid AND not hazard; ex_inst/ex_num are driven directly from the buffer.
  - Issue occurs when ex_valid && ex_ready.
  - ex_valid never drops without a handshake unless flush or reset occurs.
- Accept:
  - id_ready = !buffer_valid || issue.
  - On id_valid && id_ready, the buffer loads id_inst/id_num next edge.
  - Issue and accept in the same cycle give zero-bubble throughput.
- Counters:
  - Increment: issue with wen increments cnt[rd].
  - Decrement: wb_valid with wb wen decrements cnt[wb_rd]; kill_valid with kill wen decrements cnt[kill_rd].
  - All three events may hit the same register in one cycle; the net delta is applied (+1, -1, -1), with a range of -2..+1.
  - Decrement below 0 is a protocol error: the counter saturates at 0, with a simulation-only assertion.
  - Increment above max cannot occur because of the hazard rule.
- Flush:
  - Buffer cleared next edge; no issue in a flush cycle (ex_valid forced 0).
  - id_ready forced 0 during flush.
  - Counters unaffected: issued instructions retire via wb or kill.
- Reset mid-operation: all state returns to reset values next edge, regardless of wb/kill/flush inputs.
- hazard_stall_cycles: increments each cycle buffer valid && hazard && !flush; wraps at 2^32.

Decomposition:
- Shared package holds:
  - opcode constants
  - the writes-rd, uses-rs1 and uses-rs2 opcode lists as functions
  - NREG and register-index width
- The writes-rd list is shared with WBU so both agree on which instructions write the register file.
- One natural sub-module: regfile_pending_counter (one instance per register; inputs inc, dec_wb, dec_kill; outputs count and nonzero), generated NREG-1 times (index 0 is tied to 0).

Test Plan:
- Reset, then addi x5,x0,1 (0x00100293) with ex_ready=1 -> issues the cycle after accept; busy_mask=0x0020; wb_valid with the same word -> busy_mask=0x0000 next cycle.
- addi x5 issued, then add x6,x5,x5 (0x00528333) -> ex_valid=0 until the cycle after wb_valid for x5; hazard_stall_cycles equals the blocked cycles; x6 issues next.
- Issue lui x5,1 (0x000012b7) three times without writeback -> cnt[5]=3; a fourth lui x5 stalls with id_ready=0; one wb_valid -> fourth issues next cycle.
- Same cycle: issue addi x5 plus wb_valid and kill_valid both for x5 with cnt[5]=2 -> cnt[5]=1, busy_mask bit5=1.
- sw x5,0(x2) (0x00512023) buffered, blocked on x5, flush=1 -> buffer empty next cycle, ex_valid=0, cnt[5] unchanged; a new instruction is accepted the cycle after.
- Back-to-back independent addi x1..x4 with ex_ready=1 -> one issue per cycle, id_ready held 1; reset asserted mid-stream -> busy_mask=0, ex_valid=0 next edge.

Source files
------------

// File: rtl/regfile_issue_scoreboard_pkg.sv
// Shared decode helpers for the issue scoreboard. The writes-rd list is also used
// by WBU, so both sides agree on which instructions write the register file.
package regfile_issue_scoreboard_pkg;

    localparam int NREG      = 16;
    localparam int REG_IDX_W = $clog2(NREG);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic     wen;
        logic     rs1_en;
        logic     rs2_en;
        reg_idx_t rd;
        reg_idx_t rs1;
        reg_idx_t rs2;
    } decode_t;

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_IMM, OP_LUI, OP_AUIPC, OP_SYSTEM,
            OP_JAL, OP_JALR, OP_REG, OP_LOAD: writes_rd = 1'b1;
            default:                          writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        uses_rs1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        uses_rs2 = (op == OP_REG || op == OP_STORE || op == OP_BRANCH);
    endfunction

    // RV32E indexing: only the low 4 bits of each register field are used.
    function automatic decode_t decode(input logic [31:0] inst);
        decode_t d;
        d.rd     = inst[10:7];
        d.rs1    = inst[18:15];
        d.rs2    = inst[23:20];
        d.wen    = writes_rd(inst[6:0]) && (inst[10:7] != '0);
        d.rs1_en = uses_rs1(inst[6:0]);
        d.rs2_en = uses_rs2(inst[6:0]);
        return d;
    endfunction

endpackage

// File: rtl/regfile_issue_scoreboard_counter.sv
// Pending-write counter for one architectural register: net delta of one
// increment and two decrements per cycle, saturating at zero on underflow.
module regfile_pending_counter #(
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 dec_wb,
    input  logic                 dec_kill,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 nonzero
);

    localparam int SW = CNT_WIDTH + 2;
    localparam logic signed [SW-1:0] CNT_MAX = SW'((1 << CNT_WIDTH) - 1);

    logic signed [SW-1:0] next_sum;

    assign next_sum = $signed({2'b00, count}) + $signed(SW'(inc))
                    - $signed(SW'(dec_wb)) - $signed(SW'(dec_kill));

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (next_sum[SW-1]) begin
            count <= '0;
        end else if (next_sum > CNT_MAX) begin
            count <= CNT_MAX[CNT_WIDTH-1:0];
        end else begin
            count <= next_sum[CNT_WIDTH-1:0];
        end
    end

    assign nonzero = |count;

    // A release with nothing outstanding means WBU or the kill path misbehaved.
    underflow_chk: assert property (@(posedge clock) disable iff (reset) !next_sum[SW-1]);

endmodule

// File: rtl/regfile_issue_scoreboard.sv
// Issue-stage scoreboard: one-entry skid buffer between IDU and EXU, issuing only
// when no source is pending and the destination counter has headroom.
module regfile_issue_scoreboard #(
    parameter int NREG      = 16,
    parameter int CNT_WIDTH = 2,
    parameter int NUM_WIDTH = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [31:0]          id_inst,
    input  logic [NUM_WIDTH-1:0] id_num,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [31:0]          ex_inst,
    output logic [NUM_WIDTH-1:0] ex_num,
    input  logic                 wb_valid,
    input  logic [31:0]          wb_inst,
    input  logic                 kill_valid,
    input  logic [31:0]          kill_inst,
    input  logic                 flush,
    output logic [NREG-1:0]      busy_mask,
    output logic [31:0]          hazard_stall_cycles
);

    import regfile_issue_scoreboard_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 buf_valid;
    logic [31:0]          buf_inst;
    logic [NUM_WIDTH-1:0] buf_num;
    decode_t              buf_dec, wb_dec, kill_dec;
    logic [CNT_WIDTH-1:0] cnt [NREG];
    logic [NREG-1:0]      nonzero;
    logic                 hazard;
    logic                 issue;

    assign buf_dec  = decode(buf_inst);
    assign wb_dec   = decode(wb_inst);
    assign kill_dec = decode(kill_inst);

    // Evaluated on current counters only; a same-cycle writeback frees the stall next cycle.
    always_comb begin
        hazard = 1'b0;
        if (buf_valid) begin
            hazard = (buf_dec.rs1_en && nonzero[buf_dec.rs1])
                  || (buf_dec.rs2_en && nonzero[buf_dec.rs2])
                  || (buf_dec.wen && cnt[buf_dec.rd] == CNT_MAX);
        end
    end

    assign ex_valid  = buf_valid && !hazard && !flush;
    assign issue     = ex_valid && ex_ready;
    assign id_ready  = !flush && (!buf_valid || issue);
    assign ex_inst   = buf_inst;
    assign ex_num    = buf_num;
    assign busy_mask = nonzero;

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_valid           <= 1'b0;
            buf_inst            <= '0;
            buf_num             <= '0;
            hazard_stall_cycles <= '0;
        end else begin
            if (id_valid && id_ready) begin
                buf_valid <= 1'b1;
                buf_inst  <= id_inst;
                buf_num   <= id_num;
            end else if (issue || flush) begin
                buf_valid <= 1'b0;
            end
            if (hazard && !flush) begin
                hazard_stall_cycles <= hazard_stall_cycles + 32'd1;
            end
        end
    end

    // x0 is never written, so its counter is a constant zero.
    assign cnt[0]     = '0;
    assign nonzero[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        regfile_pending_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clock    (clock),
            .reset    (reset),
            .inc      (issue && buf_dec.wen && buf_dec.rd == REG_IDX_W'(i)),
            .dec_wb   (wb_valid && wb_dec.wen && wb_dec.rd == REG_IDX_W'(i)),
            .dec_kill (kill_valid && kill_dec.wen && kill_dec.rd == REG_IDX_W'(i)),
            .count    (cnt[i]),
            .nonzero  (nonzero[i])
        );
    end

endmodule
